de_pipe_reg: RTL and testbench

- Decode-to-Execute pipeline stage for the P5 five-stage MIPS core; directly consumes the register-file read data rf_rd1/rf_rd2 produced in D.
- Merges register-file data with forwarded results from E and M, detects load-use and branch-use hazards, and emits the stall request that freezes PC and F/D.
- Registers the D-stage instruction bundle into E, inserting a bubble (nop, ir_e=0) on stall.

---
 rtl/de_pipe_reg_pkg.sv | 34 +++
 rtl/de_pipe_reg_if.sv | 25 ++
 rtl/de_pipe_reg_instr_class.sv | 27 ++
 rtl/de_pipe_reg.sv | 52 +++++
 tb/tb_de_pipe_reg.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/de_pipe_reg_pkg.sv
// de_pipe_reg_pkg: MIPS opcode/funct constants, hazard timing encodings and helpers shared by the pipeline registers
package de_pipe_reg_pkg;
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] F_ADDU     = 6'b100001;
  localparam logic [5:0] F_SUBU     = 6'b100011;
  localparam logic [5:0] F_JR       = 6'b001000;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam int OP_HI = 31, OP_LO = 26, FUNC_HI = 5, FUNC_LO = 0;
  typedef enum logic [1:0] {TNEW_0, TNEW_1, TNEW_2} tnew_t;
  typedef enum logic [1:0] {TUSE_0, TUSE_1, TUSE_2, TUSE_NONE} tuse_t;
  typedef struct packed {
    logic       writer;
    logic [4:0] dest;
    tnew_t      tnew;
    tuse_t      tuse_rs;
    tuse_t      tuse_rt;
  } iclass_t;
  function automatic logic [5:0] op_of(input logic [31:0] ir);
    return ir[OP_HI:OP_LO];
  endfunction
  function automatic logic [5:0] func_of(input logic [31:0] ir);
    return ir[FUNC_HI:FUNC_LO];
  endfunction
  function automatic logic hazard(input logic [4:0] s, input tuse_t u, input logic [4:0] wreg_e,
                                  input tnew_t tnew_e, input logic [4:0] wreg_m, input logic ld_m);
    return s != 5'd0 && u != TUSE_NONE &&
           ((s == wreg_e && 2'(tnew_e) > 2'(u)) || (s == wreg_m && ld_m && u == TUSE_0));
  endfunction
endpackage

// File: rtl/de_pipe_reg_if.sv
// de_pipe_reg_if: D/E stage bundle; stall_cnt present only with DE_PIPE_STALL_CNT_EN
interface de_pipe_reg_if;
  logic [31:0] ir_d, pc4_d, rf_rd1, rf_rd2, ir_m, wdata_m;
  logic [4:0]  wreg_m;
  logic        stall;
  logic [31:0] fwd_rs_d, fwd_rt_d, ir_e, pc4_e, rs_e, rt_e;
  logic [4:0]  wreg_e;
`ifdef DE_PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  modport slave (
    input ir_d, pc4_d, rf_rd1, rf_rd2, ir_m, wreg_m, wdata_m,
`ifdef DE_PIPE_STALL_CNT_EN
    output stall_cnt,
`endif
    output stall, fwd_rs_d, fwd_rt_d, ir_e, pc4_e, rs_e, rt_e, wreg_e
  );
  modport master (
    output ir_d, pc4_d, rf_rd1, rf_rd2, ir_m, wreg_m, wdata_m,
`ifdef DE_PIPE_STALL_CNT_EN
    input stall_cnt,
`endif
    input stall, fwd_rs_d, fwd_rt_d, ir_e, pc4_e, rs_e, rt_e, wreg_e
  );
endinterface

// File: rtl/de_pipe_reg_instr_class.sv
// de_pipe_reg_instr_class: combinational decode of writer flag, destination, Tnew and per-source Tuse
module de_pipe_reg_instr_class
  import de_pipe_reg_pkg::*;
(
  input  logic [31:0] ir,
  output iclass_t     cls
);
  logic addu, subu, jr, ori, lw, sw, lui, beq, jal, alu;
  assign addu = op_of(ir) == OP_SPECIAL && func_of(ir) == F_ADDU;
  assign subu = op_of(ir) == OP_SPECIAL && func_of(ir) == F_SUBU;
  assign jr   = op_of(ir) == OP_SPECIAL && func_of(ir) == F_JR;
  assign ori  = op_of(ir) == OP_ORI;
  assign lw   = op_of(ir) == OP_LW;
  assign sw   = op_of(ir) == OP_SW;
  assign lui  = op_of(ir) == OP_LUI;
  assign beq  = op_of(ir) == OP_BEQ;
  assign jal  = op_of(ir) == OP_JAL;
  assign alu  = addu | subu;
  // Unsupported encodings fall through to a non-writer with no sources
  always_comb begin
    cls.writer  = alu | ori | lw | lui | jal;
    cls.dest    = alu ? ir[15:11] : (ori | lw | lui) ? ir[20:16] : jal ? 5'd31 : 5'd0;
    cls.tnew    = lw ? TNEW_2 : (alu | ori | lui) ? TNEW_1 : TNEW_0;
    cls.tuse_rs = (beq | jr) ? TUSE_0 : (alu | ori | lw | sw) ? TUSE_1 : TUSE_NONE;
    cls.tuse_rt = beq ? TUSE_0 : alu ? TUSE_1 : sw ? TUSE_2 : TUSE_NONE;
  end
endmodule

// File: rtl/de_pipe_reg.sv
// de_pipe_reg: D-to-E pipeline register with hazard stall and D-stage forwarding; DE_PIPE_STALL_CNT_EN adds stall_cnt
module de_pipe_reg
  import de_pipe_reg_pkg::*;
(
  input logic          clk,
  input logic          reset,
  de_pipe_reg_if.slave bus
);
  iclass_t     cls_d, cls_e, cls_m;
  logic [4:0]  rs_d, rt_d;
  logic [31:0] link_e;
  logic        jal_e, ld_m, alu_m, unused_cls;
  de_pipe_reg_instr_class u_cls_d (.ir(bus.ir_d), .cls(cls_d));
  de_pipe_reg_instr_class u_cls_e (.ir(bus.ir_e), .cls(cls_e));
  de_pipe_reg_instr_class u_cls_m (.ir(bus.ir_m), .cls(cls_m));
  assign rs_d       = bus.ir_d[25:21];
  assign rt_d       = bus.ir_d[20:16];
  assign link_e     = bus.pc4_e + 32'd4;
  assign jal_e      = op_of(bus.ir_e) == OP_JAL;
  assign ld_m       = cls_m.tnew == TNEW_2;
  assign alu_m      = cls_m.writer && !ld_m;
  assign unused_cls = ^{cls_d, cls_e, cls_m};
  // Pick the youngest producer whose value is already known, and stall when none is ready in time
  always_comb begin
    bus.fwd_rs_d = (rs_d != 5'd0 && jal_e && bus.wreg_e == rs_d) ? link_e :
                   (rs_d != 5'd0 && alu_m && bus.wreg_m == rs_d) ? bus.wdata_m : bus.rf_rd1;
    bus.fwd_rt_d = (rt_d != 5'd0 && jal_e && bus.wreg_e == rt_d) ? link_e :
                   (rt_d != 5'd0 && alu_m && bus.wreg_m == rt_d) ? bus.wdata_m : bus.rf_rd2;
    bus.stall    = hazard(rs_d, cls_d.tuse_rs, bus.wreg_e, cls_e.tnew, bus.wreg_m, ld_m) |
                   hazard(rt_d, cls_d.tuse_rt, bus.wreg_e, cls_e.tnew, bus.wreg_m, ld_m);
  end
  // Advance D into E, or insert a bubble on reset or stall
  always_ff @(posedge clk)
    if (reset || bus.stall) begin
      bus.ir_e   <= '0;
      bus.pc4_e  <= '0;
      bus.rs_e   <= '0;
      bus.rt_e   <= '0;
      bus.wreg_e <= '0;
    end else begin
      bus.ir_e   <= bus.ir_d;
      bus.pc4_e  <= bus.pc4_d;
      bus.rs_e   <= bus.fwd_rs_d;
      bus.rt_e   <= bus.fwd_rt_d;
      bus.wreg_e <= cls_d.dest;
    end
`ifdef DE_PIPE_STALL_CNT_EN
  // Count cycles lost to hazard stalls, wrapping at 2^32
  always_ff @(posedge clk)
    bus.stall_cnt <= reset ? '0 : bus.stall_cnt + {31'd0, bus.stall};
`endif
endmodule

// File: tb/tb_de_pipe_reg.sv
// tb_de_pipe_reg: table, corner-sequence and randomized checks of de_pipe_reg against a behavioural model
module tb_de_pipe_reg;
  localparam int NO = 9;
  typedef struct {
    bit wr;
    int dest;
    int tnew;
    int use_rs;
    int use_rt;
  } cls_t;
  typedef struct {
    logic [31:0] prev, pc4p, d, rf1, rf2, irm;
    logic [4:0]  wrm;
    logic [31:0] wdm;
    logic        st;
    logic [31:0] ers, ert;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  int n_chk = 0, n_fail = 0;
  logic [31:0] m_ir, m_pc4, m_rs, m_rt;
  int m_wreg;
  vec_t tbl[11];
  always #5 clk = ~clk;
  de_pipe_reg_if bus();
  de_pipe_reg dut (.clk(clk), .reset(reset), .bus(bus.slave));
  function automatic cls_t classify(input logic [31:0] w);
    cls_t c;
    c.wr = 0; c.dest = 0; c.tnew = 0; c.use_rs = NO; c.use_rt = NO;
    case (w[31:26])
      6'h00: case (w[5:0])
        6'h21, 6'h23: begin c.wr = 1; c.dest = int'(w[15:11]); c.tnew = 1; c.use_rs = 1; c.use_rt = 1; end
        6'h08: c.use_rs = 0;
        default: ;
      endcase
      6'h0d: begin c.wr = 1; c.dest = int'(w[20:16]); c.tnew = 1; c.use_rs = 1; end
      6'h0f: begin c.wr = 1; c.dest = int'(w[20:16]); c.tnew = 1; end
      6'h23: begin c.wr = 1; c.dest = int'(w[20:16]); c.tnew = 2; c.use_rs = 1; end
      6'h2b: begin c.use_rs = 1; c.use_rt = 2; end
      6'h04: begin c.use_rs = 0; c.use_rt = 0; end
      6'h03: begin c.wr = 1; c.dest = 31; end
      default: ;
    endcase
    return c;
  endfunction
  function automatic logic m_stall();
    cls_t d = classify(bus.ir_d);
    cls_t e = classify(m_ir);
    int srcs[2];
    int uses[2];
    logic s = 1'b0;
    srcs[0] = int'(bus.ir_d[25:21]); srcs[1] = int'(bus.ir_d[20:16]);
    uses[0] = d.use_rs; uses[1] = d.use_rt;
    for (int k = 0; k < 2; k++)
      if (srcs[k] != 0 && uses[k] != NO) begin
        if (srcs[k] == m_wreg && e.tnew > uses[k]) s = 1'b1;
        if (srcs[k] == int'(bus.wreg_m) && bus.ir_m[31:26] == 6'h23 && uses[k] == 0) s = 1'b1;
      end
    return s;
  endfunction
  function automatic logic [31:0] m_fwd(input int s, input logic [31:0] rf);
    cls_t mm = classify(bus.ir_m);
    if (s == 0) return rf;
    if (m_ir[31:26] == 6'h03 && m_wreg == s) return m_pc4 + 32'd4;
    if (int'(bus.wreg_m) == s && mm.wr && bus.ir_m[31:26] != 6'h23) return bus.wdata_m;
    return rf;
  endfunction
  function automatic logic [4:0] rreg();
    logic [4:0] r;
    case ($urandom_range(0, 5))
      0: r = 5'd0;
      1: r = 5'd1;
      2: r = 5'd2;
      3: r = 5'd3;
      4: r = 5'd31;
      default: r = 5'($urandom_range(0, 31));
    endcase
    return r;
  endfunction
  function automatic logic [31:0] rnd_instr();
    logic [4:0] a, b, c;
    logic [15:0] imm;
    logic [31:0] w;
    a = rreg(); b = rreg(); c = rreg(); imm = 16'($urandom);
    case ($urandom_range(0, 10))
      0: w = {6'h00, a, b, c, 5'h0, 6'h21};
      1: w = {6'h00, a, b, c, 5'h0, 6'h23};
      2: w = {6'h0d, a, b, imm};
      3: w = {6'h23, a, b, imm};
      4: w = {6'h2b, a, b, imm};
      5: w = {6'h0f, 5'h0, b, imm};
      6: w = {6'h04, a, b, imm};
      7: w = {6'h03, 26'($urandom)};
      8: w = {6'h00, a, 15'h0, 6'h08};
      9: w = 32'h0;
      default: w = {6'h3f, 26'($urandom)};
    endcase
    return w;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    logic st;
    logic [31:0] frs, frt;
    st  = m_stall();
    frs = m_fwd(int'(bus.ir_d[25:21]), bus.rf_rd1);
    frt = m_fwd(int'(bus.ir_d[20:16]), bus.rf_rd2);
    @(posedge clk);
    if (reset || st) begin
      m_ir = 0; m_pc4 = 0; m_rs = 0; m_rt = 0; m_wreg = 0;
    end else begin
      m_ir = bus.ir_d; m_pc4 = bus.pc4_d; m_rs = frs; m_rt = frt; m_wreg = classify(bus.ir_d).dest;
    end
    #1;
  endtask
  task automatic quiet_inputs();
    bus.ir_d = 0; bus.pc4_d = 0; bus.rf_rd1 = 0; bus.rf_rd2 = 0;
    bus.ir_m = 0; bus.wreg_m = 0; bus.wdata_m = 0;
  endtask
  initial begin
    m_ir = 0; m_pc4 = 0; m_rs = 0; m_rt = 0; m_wreg = 0;
    quiet_inputs();
    reset = 1'b1;
    bus.ir_d = 32'h00221821; bus.pc4_d = 32'h1004;
    cyc();
    chk("rst_ir_e", bus.ir_e, 0);
    chk("rst_pc4_e", bus.pc4_e, 0);
    chk("rst_rs_e", bus.rs_e, 0);
    chk("rst_rt_e", bus.rt_e, 0);
    chk("rst_wreg_e", 32'(bus.wreg_e), 0);
    chk("rst_stall", 32'(bus.stall), 0);
    reset = 1'b0;
    cyc();
    chk("post_rst_ir_e", bus.ir_e, 32'h00221821);
    chk("post_rst_wreg_e", 32'(bus.wreg_e), 3);
    chk("post_rst_pc4_e", bus.pc4_e, 32'h1004);
    tbl[0]  = '{32'h8C050000, 32'h0,        32'h00A53021, 32'h11, 32'h22, 32'h0,        5'd0, 32'h0,  1'b1, 32'h11,   32'h22};
    tbl[1]  = '{32'h0,        32'h0,        32'h10840000, 32'hAA, 32'hBB, 32'h34040012, 5'd4, 32'h12, 1'b0, 32'h12,   32'h12};
    tbl[2]  = '{32'h0C000100, 32'h3004,     32'h03E00008, 32'h55, 32'h0,  32'h0,        5'd0, 32'h0,  1'b0, 32'h3008, 32'h0};
    tbl[3]  = '{32'h00220021, 32'h0,        32'h10000000, 32'h0,  32'h0,  32'h0,        5'd0, 32'h0,  1'b0, 32'h0,    32'h0};
    tbl[4]  = '{32'h8C050000, 32'h0,        32'hAC450000, 32'h33, 32'h44, 32'h0,        5'd0, 32'h0,  1'b0, 32'h33,   32'h44};
    tbl[5]  = '{32'h00221821, 32'h0,        32'h10600000, 32'h66, 32'h0,  32'h0,        5'd0, 32'h0,  1'b1, 32'h66,   32'h0};
    tbl[6]  = '{32'h0,        32'h0,        32'h10A50000, 32'h1,  32'h2,  32'h8C050000, 5'd5, 32'h99, 1'b1, 32'h1,    32'h2};
    tbl[7]  = '{32'h0,        32'h0,        32'h00A53021, 32'h1,  32'h2,  32'h8C050000, 5'd5, 32'h99, 1'b0, 32'h1,    32'h2};
    tbl[8]  = '{32'h0,        32'h0,        32'h10000000, 32'h0,  32'h0,  32'h00220021, 5'd0, 32'h77, 1'b0, 32'h0,    32'h0};
    tbl[9]  = '{32'h0C000100, 32'hFFFFFFFC, 32'h03E00008, 32'h55, 32'h0,  32'h0,        5'd0, 32'h0,  1'b0, 32'h0,    32'h0};
    tbl[10] = '{32'h00221821, 32'h0,        32'h34670001, 32'h5,  32'h44, 32'h34030012, 5'd3, 32'h12, 1'b0, 32'h12,   32'h44};
    for (int i = 0; i < 11; i++) begin
      quiet_inputs();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      bus.ir_d = tbl[i].prev; bus.pc4_d = tbl[i].pc4p;
      cyc();
      bus.ir_d = tbl[i].d; bus.rf_rd1 = tbl[i].rf1; bus.rf_rd2 = tbl[i].rf2;
      bus.ir_m = tbl[i].irm; bus.wreg_m = tbl[i].wrm; bus.wdata_m = tbl[i].wdm;
      #1;
      chk($sformatf("tbl%0d_stall", i), 32'(bus.stall), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_fwd_rs", i), bus.fwd_rs_d, tbl[i].ers);
      chk($sformatf("tbl%0d_fwd_rt", i), bus.fwd_rt_d, tbl[i].ert);
    end
    quiet_inputs();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.ir_d = 32'h8C050000;
    cyc();
    bus.ir_d = 32'h00A53021; bus.pc4_d = 32'h2008;
    #1 chk("lwuse_stall", 32'(bus.stall), 1);
    cyc();
    chk("lwuse_bubble", bus.ir_e, 0);
    chk("lwuse_released", 32'(bus.stall), 0);
    cyc();
    chk("lwuse_enter", bus.ir_e, 32'h00A53021);
    chk("lwuse_pc4", bus.pc4_e, 32'h2008);
    quiet_inputs();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.ir_d = 32'h8C050000;
    cyc();
    bus.ir_d = 32'h10A50000;
    #1 chk("lwbeq_stall1", 32'(bus.stall), 1);
    cyc();
    bus.ir_m = 32'h8C050000; bus.wreg_m = 5'd5;
    #1 chk("lwbeq_stall2", 32'(bus.stall), 1);
    cyc();
    bus.ir_m = 0; bus.wreg_m = 0;
    #1 chk("lwbeq_release", 32'(bus.stall), 0);
    chk("lwbeq_bubble", bus.ir_e, 0);
    cyc();
    chk("lwbeq_enter", bus.ir_e, 32'h10A50000);
`ifdef DE_PIPE_STALL_CNT_EN
    chk("stall_cnt_two", bus.stall_cnt, 2);
    reset = 1'b1;
    cyc();
    chk("stall_cnt_clr", bus.stall_cnt, 0);
    reset = 1'b0;
`endif
    quiet_inputs();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.ir_d = 32'h8C050000;
    cyc();
    bus.ir_d = 32'h00A53021;
    #1 chk("midrst_stall", 32'(bus.stall), 1);
    reset = 1'b1;
    cyc();
    chk("midrst_ir_e", bus.ir_e, 0);
    chk("midrst_stall_after", 32'(bus.stall), 0);
    reset = 1'b0;
    cyc();
    chk("midrst_enter", bus.ir_e, 32'h00A53021);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 39) == 0);
      bus.ir_d = rnd_instr(); bus.pc4_d = $urandom;
      bus.rf_rd1 = $urandom; bus.rf_rd2 = $urandom;
      bus.ir_m = rnd_instr(); bus.wreg_m = 5'(classify(bus.ir_m).dest); bus.wdata_m = $urandom;
      #1;
      chk("rnd_stall", 32'(bus.stall), 32'(m_stall()));
      chk("rnd_fwd_rs", bus.fwd_rs_d, m_fwd(int'(bus.ir_d[25:21]), bus.rf_rd1));
      chk("rnd_fwd_rt", bus.fwd_rt_d, m_fwd(int'(bus.ir_d[20:16]), bus.rf_rd2));
      cyc();
      chk("rnd_ir_e", bus.ir_e, m_ir);
      chk("rnd_pc4_e", bus.pc4_e, m_pc4);
      chk("rnd_rs_e", bus.rs_e, m_rs);
      chk("rnd_rt_e", bus.rt_e, m_rt);
      chk("rnd_wreg_e", 32'(bus.wreg_e), 32'(m_wreg));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
